// File: rtl/conv_result_summarizer.sv
// Reduces each kernel's 25 convolution results to a max and a sum, and queues
// the per-kernel summaries in a small FIFO drained over a valid/ready interface.
module conv_result_summarizer #(
  parameter int DATA_W     = 8,
  parameter int NUM_KERNEL = 6,
  parameter int PER_KERNEL = 25,
  parameter int SUM_W      = 13,
  parameter int RES_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2:0]        out_kernel_id,
  output logic [DATA_W-1:0] out_max,
  output logic [SUM_W-1:0]  out_sum,
  output logic              frame_done,
  output logic              overflow
);

  localparam int ELEM_W = $clog2(PER_KERNEL);
  localparam int KERN_W = 3;
  localparam int PTR_W  = $clog2(RES_DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  typedef enum logic {
    IDLE,
    ACCUM
  } state_t;

  state_t state, state_next;

  logic [ELEM_W-1:0] elem_cnt;
  logic [KERN_W-1:0] kern_cnt;
  logic [DATA_W-1:0] acc_max;
  logic [SUM_W-1:0]  acc_sum;

  logic              last_elem;
  logic              last_kern;
  logic              frame_start;
  logic              frame_end;
  logic [SUM_W-1:0]  data_ext;
  logic [DATA_W-1:0] beat_max;
  logic [SUM_W-1:0]  beat_sum;

  logic [KERN_W-1:0] fifo_id  [RES_DEPTH];
  logic [DATA_W-1:0] fifo_max [RES_DEPTH];
  logic [SUM_W-1:0]  fifo_sum [RES_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  fifo_cnt;
  logic              fifo_full;
  logic              push_req;
  logic              push_ok;
  logic              pop;
  logic              drop;

  assign last_elem   = (elem_cnt == ELEM_W'(PER_KERNEL - 1));
  assign last_kern   = (kern_cnt == KERN_W'(NUM_KERNEL - 1));
  assign frame_start = in_valid && (state == IDLE);
  assign frame_end   = in_valid && last_elem && last_kern;
  assign data_ext    = {{(SUM_W - DATA_W){1'b0}}, in_data};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = ACCUM;
      ACCUM:   if (frame_end) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The summary of the current beat includes the beat itself, so the value
  // pushed on the last element is this combinational result, not acc_*.
  always_comb begin
    beat_max = in_data;
    beat_sum = data_ext;
    if (elem_cnt != '0) begin
      beat_sum = acc_sum + data_ext;
      if (acc_max > in_data) beat_max = acc_max;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      elem_cnt <= '0;
      kern_cnt <= '0;
      acc_max  <= '0;
      acc_sum  <= '0;
    end else if (in_valid) begin
      acc_max <= beat_max;
      acc_sum <= beat_sum;
      if (last_elem) begin
        elem_cnt <= '0;
        kern_cnt <= last_kern ? '0 : kern_cnt + KERN_W'(1);
      end else begin
        elem_cnt <= elem_cnt + ELEM_W'(1);
      end
    end
  end

  assign out_valid = (fifo_cnt != '0);
  assign fifo_full = (fifo_cnt == CNT_W'(RES_DEPTH));
  assign pop       = out_valid && out_ready;
  assign push_req  = in_valid && last_elem;
  // A pop in the same cycle frees the head slot, which the push then reuses.
  assign push_ok   = push_req && (!fifo_full || pop);
  assign drop      = push_req && fifo_full && !pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RES_DEPTH; i++) begin
        fifo_id[i]  <= '0;
        fifo_max[i] <= '0;
        fifo_sum[i] <= '0;
      end
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push_ok) begin
        fifo_id[wr_ptr]  <= kern_cnt;
        fifo_max[wr_ptr] <= beat_max;
        fifo_sum[wr_ptr] <= beat_sum;
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push_ok, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  assign out_kernel_id = fifo_id[rd_ptr];
  assign out_max       = fifo_max[rd_ptr];
  assign out_sum       = fifo_sum[rd_ptr];

  // A drop on the opening beat of a frame wins over the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      frame_done <= frame_end;
      if (drop) begin
        overflow <= 1'b1;
      end else if (frame_start) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_conv_result_summarizer.sv
// Directed bench for conv_result_summarizer: expected summaries go into a
// scoreboard queue as stimulus is driven and are compared on each handshake.
module tb_conv_result_summarizer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_kernel_id;
  logic [7:0]  out_max;
  logic [12:0] out_sum;
  logic        frame_done;
  logic        overflow;

  typedef struct {
    logic [2:0]  id;
    logic [7:0]  mx;
    logic [12:0] sm;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  logic [7:0] vals[25];
  int         n_checks = 0;
  int         n_pass   = 0;
  int         done_cnt = 0;
  bit         chk_ovf_first = 1'b0;

  conv_result_summarizer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_kernel_id (out_kernel_id),
    .out_max       (out_max),
    .out_sum       (out_sum),
    .frame_done    (frame_done),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Outputs are sampled on the falling edge; a handshake seen here completes
  // at the following rising edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (frame_done === 1'b1) done_cnt++;
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        check_output("sb_has_entry_on_pop", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          check_output("out_kernel_id", 32'(out_kernel_id), 32'(mon_e.id));
          check_output("out_max", 32'(out_max), 32'(mon_e.mx));
          check_output("out_sum", 32'(out_sum), 32'(mon_e.sm));
        end
      end
    end
  end

  task automatic fill_const(input int v);
    for (int i = 0; i < 25; i++) vals[i] = 8'(v);
  endtask

  // Drives one kernel's 25 beats from vals[]; its expected summary is queued
  // only when the summary is meant to survive the FIFO.
  task automatic apply_stimulus(input int k, input int gapmax, input bit keep, input bit ready_last);
    exp_t e;
    int   s;
    int   m;
    int   g;
    s = 0;
    m = 0;
    for (int i = 0; i < 25; i++) begin
      s += int'(vals[i]);
      if (int'(vals[i]) > m) m = int'(vals[i]);
    end
    e.id = 3'(k);
    e.mx = 8'(m);
    e.sm = 13'(s);
    for (int i = 0; i < 25; i++) begin
      if (gapmax > 0) begin
        g = int'($urandom_range(gapmax, 0));
        repeat (g) begin
          @(posedge clk);
          #1;
        end
      end
      if (i == 24) begin
        if (keep) sb.push_back(e);
        if (ready_last) out_ready = 1'b1;
      end
      in_valid = 1'b1;
      in_data  = vals[i];
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      if (i == 0 && chk_ovf_first) begin
        check_output("overflow_cleared_first_beat", 32'(overflow), 0);
        chk_ovf_first = 1'b0;
      end
    end
  endtask

  task automatic run_frame(input int gapmax);
    for (int k = 0; k < 6; k++) begin
      fill_const(k + 1);
      apply_stimulus(k, gapmax, 1'b1, 1'b0);
    end
  endtask

  task automatic end_of_frame_checks(input string tag, input logic exp_ovf);
    check_output({tag, "_frame_done_pulse"}, 32'(frame_done), 1);
    @(posedge clk);
    #1;
    check_output({tag, "_frame_done_low"}, 32'(frame_done), 0);
    check_output({tag, "_frame_done_count"}, 32'(done_cnt), 1);
    check_output({tag, "_overflow"}, 32'(overflow), 32'(exp_ovf));
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 64 && sb.size() != 0; i++) @(posedge clk);
    #1;
    check_output({tag, "_drain_left"}, 32'(sb.size()), 0);
    @(posedge clk);
    #1;
    check_output({tag, "_out_valid_after_drain"}, 32'(out_valid), 0);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    sb.delete();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    out_ready = 1'b1;
    do_reset();
    check_output("reset_out_valid", 32'(out_valid), 0);
    check_output("reset_overflow", 32'(overflow), 0);
    check_output("reset_frame_done", 32'(frame_done), 0);
    check_output("reset_kernel_id", 32'(out_kernel_id), 0);
    check_output("reset_max", 32'(out_max), 0);
    check_output("reset_sum", 32'(out_sum), 0);

    $display("[TB] constant-per-kernel frame");
    done_cnt = 0;
    run_frame(0);
    end_of_frame_checks("t1", 1'b0);
    wait_drain("t1");

    $display("[TB] ascending kernel 0 with spike");
    done_cnt = 0;
    for (int i = 0; i < 25; i++) vals[i] = 8'(i);
    vals[12] = 8'd196;
    apply_stimulus(0, 0, 1'b1, 1'b0);
    for (int k = 1; k < 6; k++) begin
      fill_const(k + 1);
      apply_stimulus(k, 0, 1'b1, 1'b0);
    end
    end_of_frame_checks("t2", 1'b0);
    wait_drain("t2");

    $display("[TB] consumer stalled for a whole frame");
    out_ready = 1'b0;
    done_cnt  = 0;
    for (int k = 0; k < 6; k++) begin
      fill_const(k + 1);
      apply_stimulus(k, 0, (k < 4), 1'b0);
    end
    end_of_frame_checks("t3", 1'b1);
    check_output("t3_head_valid", 32'(out_valid), 1);
    check_output("t3_head_id", 32'(out_kernel_id), 0);
    repeat (3) @(posedge clk);
    #1;
    check_output("t3_head_id_held", 32'(out_kernel_id), 0);
    check_output("t3_head_sum_held", 32'(out_sum), 25);
    out_ready = 1'b1;
    wait_drain("t3");
    check_output("t3_overflow_sticky", 32'(overflow), 1);
    done_cnt      = 0;
    chk_ovf_first = 1'b1;
    run_frame(0);
    check_output("t3_ovf_check_consumed", 32'(chk_ovf_first), 0);
    end_of_frame_checks("t3b", 1'b0);
    wait_drain("t3b");

    $display("[TB] full FIFO with simultaneous pop and push");
    out_ready = 1'b0;
    done_cnt  = 0;
    for (int k = 0; k < 4; k++) begin
      fill_const(k + 1);
      apply_stimulus(k, 0, 1'b1, 1'b0);
    end
    check_output("t4_full_valid", 32'(out_valid), 1);
    fill_const(5);
    apply_stimulus(4, 0, 1'b1, 1'b1);
    check_output("t4_no_drop", 32'(overflow), 0);
    fill_const(6);
    apply_stimulus(5, 0, 1'b1, 1'b0);
    end_of_frame_checks("t4", 1'b0);
    wait_drain("t4");

    $display("[TB] random input gaps");
    out_ready = 1'b1;
    done_cnt  = 0;
    run_frame(7);
    end_of_frame_checks("t5", 1'b0);
    wait_drain("t5");

    $display("[TB] reset in the middle of a frame");
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      fill_const(k + 1);
      apply_stimulus(k, 0, 1'b1, 1'b0);
    end
    fill_const(3);
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_data  = vals[i];
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
    check_output("t6_queued_before_reset", 32'(out_valid), 1);
    rst_n = 1'b0;
    sb.delete();
    #1;
    check_output("t6_valid_in_reset", 32'(out_valid), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_output("t6_no_stale_valid", 32'(out_valid), 0);
    check_output("t6_overflow_clear", 32'(overflow), 0);
    out_ready = 1'b1;
    done_cnt  = 0;
    run_frame(0);
    end_of_frame_checks("t6", 1'b0);
    wait_drain("t6");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
